// File: rtl/ram_lsu_if.sv
// Request/response and RAM-side bus of the load/store unit.
// The master modport is the LSU's view; the slave modport is the view of the
// core memory stage and the RAM.
interface ram_lsu_if #(
    parameter int ADDR_WIDTH = 10
);
    // core-side request
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [31:0]           req_addr_i;
    logic [31:0]           req_wdata_i;
    // core-side response
    logic                  rsp_valid_o;
    logic                  rsp_err_o;
    logic [31:0]           rsp_rdata_o;
    // RAM side
    logic [3:0]            ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [31:0]           ram_wdata_o;
    logic [31:0]           ram_rdata_i;

    modport master (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, ram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
               ram_we_o, ram_addr_o, ram_wdata_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, ram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
               ram_we_o, ram_addr_o, ram_wdata_o
    );
endinterface

// File: rtl/ram_lsu_master.sv
// Load/store unit driving a 1-cycle synchronous-read, byte-write RAM.
// One request at a time: IDLE -> ACCESS -> RESP for legal accesses,
// IDLE -> RESP with error for misaligned or illegal-size requests.
module ram_lsu_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    ram_lsu_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // size encoding
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Legal size with natural alignment.
    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (lo[0] == 1'b0);
            SZ_WORD: ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane write enables for a store of the given size at offset lo.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lo;
            SZ_HALF: be = 4'b0011 << lo;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across all lanes; the enables pick the lane.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wd[7:0]}};
            SZ_HALF: d = {2{wd[15:0]}};
            SZ_WORD: d = wd;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // Select the addressed lane of a RAM word and zero/sign-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] rd,
                                                input logic [1:0]  lo,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            2'd3:    b = rd[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            SZ_WORD: r = rd;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t                state_r;
    logic                  ready_r;
    logic                  rsp_valid_r;
    logic                  rsp_err_r;
    logic [3:0]            ram_we_r;
    logic [ADDR_WIDTH-1:0] ram_addr_r;
    logic [DATA_WIDTH-1:0] ram_wdata_r;

    // Request attributes captured at the handshake, used to format the load response.
    logic [1:0]            lo_r;
    logic [1:0]            size_r;
    logic                  unsigned_r;
    logic                  load_ok_r;

    logic                  hs_s;
    logic                  legal_s;
    logic [31:0]           rsp_rdata_s;

    assign hs_s    = bus.req_valid_i & ready_r;
    assign legal_s = is_legal(bus.req_size_i, bus.req_addr_i[1:0]);

    // Access sequencer: one request in flight, every output registered except load data.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r     <= ST_IDLE;
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            ram_we_r    <= 4'b0000;
            ram_addr_r  <= '0;
            ram_wdata_r <= '0;
            lo_r        <= 2'b00;
            size_r      <= 2'b00;
            unsigned_r  <= 1'b0;
            load_ok_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    ram_we_r    <= 4'b0000;
                    ram_wdata_r <= '0;
                    if (hs_s) begin
                        ready_r    <= 1'b0;
                        lo_r       <= bus.req_addr_i[1:0];
                        size_r     <= bus.req_size_i;
                        unsigned_r <= bus.req_unsigned_i;
                        if (legal_s) begin
                            state_r    <= ST_ACCESS;
                            load_ok_r  <= ~bus.req_we_i;
                            ram_addr_r <= bus.req_addr_i[ADDR_WIDTH+1:2];
                            if (bus.req_we_i) begin
                                ram_we_r    <= byte_en(bus.req_size_i, bus.req_addr_i[1:0]);
                                ram_wdata_r <= store_data(bus.req_size_i, bus.req_wdata_i);
                            end else begin
                                ram_we_r    <= 4'b0000;
                                ram_wdata_r <= '0;
                            end
                        end else begin
                            // Rejected request: answer immediately, never touch the RAM.
                            state_r     <= ST_RESP;
                            load_ok_r   <= 1'b0;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    state_r     <= ST_RESP;
                    ready_r     <= 1'b0;
                    ram_we_r    <= 4'b0000;
                    ram_wdata_r <= '0;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                end
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    ready_r     <= 1'b1;
                    ram_we_r    <= 4'b0000;
                    ram_wdata_r <= '0;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    load_ok_r   <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ready_r     <= 1'b0;
                    ram_we_r    <= 4'b0000;
                    ram_wdata_r <= '0;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    load_ok_r   <= 1'b0;
                end
            endcase
        end
    end

    // Load data arrives from the RAM during RESP, so it is formatted combinationally.
    always_comb begin
        rsp_rdata_s = 32'h0000_0000;
        if (state_r == ST_RESP && load_ok_r) begin
            rsp_rdata_s = load_extend(bus.ram_rdata_i, lo_r, size_r, unsigned_r);
        end else begin
            rsp_rdata_s = 32'h0000_0000;
        end
    end

    assign bus.req_ready_o = ready_r;
    assign bus.rsp_valid_o = rsp_valid_r;
    assign bus.rsp_err_o   = rsp_err_r;
    assign bus.rsp_rdata_o = rsp_rdata_s;
    assign bus.ram_we_o    = ram_we_r;
    assign bus.ram_addr_o  = ram_addr_r;
    assign bus.ram_wdata_o = ram_wdata_r;

endmodule
